// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg
//   Shared definitions for the writeback-port arbiter and the register
//   controller that consumes its commands.
//   - Default sizes: NUM_REQ_DEF, ADDR_W_DEF, DATA_W_DEF
//   - wb_cmd_t: one writeback command (enable, address, data)
//   - ptr_width(): index width for an N-entry round-robin pointer
//   - next_idx(): index + 1 wrapped modulo N
package wb_port_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned DATA_W_DEF  = 16;

  typedef struct packed {
    logic                  en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_cmd_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned next_idx(input int unsigned idx,
                                           input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// wb_port_arbiter_rr_pick
//   Combinational rotate-and-find-first: scans vec_i starting at start_i,
//   wrapping modulo N, and reports the first set bit.
//   Ports:
//     vec_i    in  N      candidate vector
//     start_i  in  IDX_W  index where the scan begins
//     onehot_o out N      one-hot of the chosen index (0 if none)
//     idx_o    out IDX_W  chosen index (0 if none)
//     found_o  out 1      a set bit was found
module wb_port_arbiter_rr_pick
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned N = NUM_REQ_DEF,
  localparam int unsigned IDX_W = ptr_width(N)
) (
  input  logic [N-1:0]     vec_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    int unsigned j;
    logic        hit;
    j        = 0;
    hit      = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(start_i) + k) % N;
      if (!hit && vec_i[j]) begin
        hit         = 1'b1;
        idx_o       = IDX_W'(j);
        onehot_o[j] = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Round-robin arbiter sharing the register file's two writeback ports
//   among NUM_REQ requesters. Up to two grants per cycle (A first in search
//   order, B next with a different address); grants become registered write
//   commands one cycle later.
//   Ports:
//     clock_i        in  1               clock
//     reset_i        in  1               synchronous active-low reset
//     reqValid_i     in  NUM_REQ         request valid per requester
//     reqAddr_i      in  NUM_REQ*ADDR_W  packed request addresses
//     reqData_i      in  NUM_REQ*DATA_W  packed request data
//     reqReady_o     out NUM_REQ         combinational grant
//     wbA_o/wbAddrA_o/wbValA_o           port A registered command
//     wbB_o/wbAddrB_o/wbValB_o           port B registered command
//     conflictCnt_o  out 8               saturating same-address skip count
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        reqValid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] reqAddr_i,
  input  logic [NUM_REQ*DATA_W-1:0] reqData_i,
  output logic [NUM_REQ-1:0]        reqReady_o,
  output logic                      wbA_o,
  output logic [ADDR_W-1:0]         wbAddrA_o,
  output logic [DATA_W-1:0]         wbValA_o,
  output logic                      wbB_o,
  output logic [ADDR_W-1:0]         wbAddrB_o,
  output logic [DATA_W-1:0]         wbValB_o,
  output logic [7:0]                conflictCnt_o
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0] valid_eff;
  logic [NUM_REQ-1:0] hot_a, hot_b, same_addr, collide, mask_b;
  logic [PTR_W-1:0]   idx_a, idx_b, start_b;
  logic               found_a, found_b, conflict;
  logic [ADDR_W-1:0]  addr_a, addr_b;
  logic [DATA_W-1:0]  data_a, data_b;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               wb_a_q, wb_a_d, wb_b_q, wb_b_d;
  logic [ADDR_W-1:0]  wb_addr_a_q, wb_addr_a_d, wb_addr_b_q, wb_addr_b_d;
  logic [DATA_W-1:0]  wb_val_a_q, wb_val_a_d, wb_val_b_q, wb_val_b_d;
  logic [7:0]         cnt_q, cnt_d;

  // Gating the candidates with reset keeps reqReady_o low during reset.
  assign valid_eff = reqValid_i & {NUM_REQ{reset_i}};

  wb_port_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_a (
    .vec_i    (valid_eff),
    .start_i  (rr_ptr_q),
    .onehot_o (hot_a),
    .idx_o    (idx_a),
    .found_o  (found_a)
  );

  assign addr_a = reqAddr_i[32'(idx_a)*ADDR_W +: ADDR_W];
  assign data_a = reqData_i[32'(idx_a)*DATA_W +: DATA_W];

  always_comb begin
    same_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      same_addr[i] = (reqAddr_i[i*ADDR_W +: ADDR_W] == addr_a);
    end
  end

  assign collide = valid_eff & same_addr & ~hot_a;
  assign mask_b  = valid_eff & ~hot_a & ~same_addr;
  // Everything between rrPtr and A is invalid, so starting B's scan just
  // after A is the same as continuing A's search order.
  assign start_b = PTR_W'(next_idx(32'(idx_a), NUM_REQ));

  wb_port_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_b (
    .vec_i    (mask_b),
    .start_i  (start_b),
    .onehot_o (hot_b),
    .idx_o    (idx_b),
    .found_o  (found_b)
  );

  assign addr_b = reqAddr_i[32'(idx_b)*ADDR_W +: ADDR_W];
  assign data_b = reqData_i[32'(idx_b)*DATA_W +: DATA_W];

  assign reqReady_o = hot_a | hot_b;

  // A colliding requester counts only if B's scan actually passed over it:
  // it lies strictly between A and B in search order, or B found nothing.
  always_comb begin
    int unsigned dist_i, dist_b;
    dist_i   = 0;
    conflict = 1'b0;
    dist_b   = (32'(idx_b) + NUM_REQ - 32'(idx_a)) % NUM_REQ;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      dist_i = (i + NUM_REQ - 32'(idx_a)) % NUM_REQ;
      if (collide[i] && (!found_b || dist_i < dist_b)) begin
        conflict = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    if (found_b) begin
      rr_ptr_d = PTR_W'(next_idx(32'(idx_b), NUM_REQ));
    end else if (found_a) begin
      rr_ptr_d = PTR_W'(next_idx(32'(idx_a), NUM_REQ));
    end
    wb_a_d      = found_a;
    wb_addr_a_d = found_a ? addr_a : '0;
    wb_val_a_d  = found_a ? data_a : '0;
    wb_b_d      = found_b;
    wb_addr_b_d = found_b ? addr_b : '0;
    wb_val_b_d  = found_b ? data_b : '0;
    cnt_d       = cnt_q;
    if (conflict && cnt_q != '1) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      rr_ptr_q    <= '0;
      wb_a_q      <= 1'b0;
      wb_addr_a_q <= '0;
      wb_val_a_q  <= '0;
      wb_b_q      <= 1'b0;
      wb_addr_b_q <= '0;
      wb_val_b_q  <= '0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wb_a_q      <= wb_a_d;
      wb_addr_a_q <= wb_addr_a_d;
      wb_val_a_q  <= wb_val_a_d;
      wb_b_q      <= wb_b_d;
      wb_addr_b_q <= wb_addr_b_d;
      wb_val_b_q  <= wb_val_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wbA_o         = wb_a_q;
  assign wbAddrA_o     = wb_addr_a_q;
  assign wbValA_o      = wb_val_a_q;
  assign wbB_o         = wb_b_q;
  assign wbAddrB_o     = wb_addr_b_q;
  assign wbValB_o      = wb_val_b_q;
  assign conflictCnt_o = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed table of per-cycle vectors for wb_port_arbiter (4 requesters),
//   followed by hand-written mid-operation reset and counter saturation runs.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [19:0] addr;
  logic [63:0] data;
  logic [3:0]  ready;
  logic        wbA, wbB;
  logic [4:0]  wbAddrA, wbAddrB;
  logic [15:0] wbValA, wbValB;
  logic [7:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(16)) dut (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .reqValid_i    (valid),
    .reqAddr_i     (addr),
    .reqData_i     (data),
    .reqReady_o    (ready),
    .wbA_o         (wbA),
    .wbAddrA_o     (wbAddrA),
    .wbValA_o      (wbValA),
    .wbB_o         (wbB),
    .wbAddrB_o     (wbAddrB),
    .wbValB_o      (wbValB),
    .conflictCnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [19:0] addr;
    logic [63:0] data;
    logic [3:0]  ready;
    logic        wbA;
    logic [4:0]  addrA;
    logic [15:0] valA;
    logic        wbB;
    logic [4:0]  addrB;
    logic [15:0] valB;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at negedge, check combinational ready before the posedge,
  // then check the registered command #1 after the posedge.
  task automatic apply(input vec_t v, input int k);
    @(negedge clk);
    rst_n = v.rst_n;
    valid = v.valid;
    addr  = v.addr;
    data  = v.data;
    #1;
    check($sformatf("v%0d ready", k), 32'(ready), 32'(v.ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d wbA", k), 32'(wbA), 32'(v.wbA));
    check($sformatf("v%0d wbB", k), 32'(wbB), 32'(v.wbB));
    check($sformatf("v%0d cnt", k), 32'(cnt), 32'(v.cnt));
    if (v.wbA) begin
      check($sformatf("v%0d addrA", k), 32'(wbAddrA), 32'(v.addrA));
      check($sformatf("v%0d valA", k), 32'(wbValA), 32'(v.valA));
    end
    if (v.wbB) begin
      check($sformatf("v%0d addrB", k), 32'(wbAddrB), 32'(v.addrB));
      check($sformatf("v%0d valB", k), 32'(wbValB), 32'(v.valB));
    end
  endtask

  logic [19:0] a_dist;
  logic [63:0] d_dist;

  initial begin
    rst_n = 1'b0;
    valid = '0;
    addr  = '0;
    data  = '0;
    a_dist = {5'd4, 5'd3, 5'd2, 5'd1};
    d_dist = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    // reset held with all valid: no grants, outputs cleared
    tbl[0]  = '{1'b0, 4'b1111, a_dist, d_dist, 4'b0000, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 8'd0};
    // first cycle after release: A=0, B=1; ptr -> 2
    tbl[1]  = '{1'b1, 4'b1111, a_dist, d_dist, 4'b0011, 1'b1, 5'd1, 16'hA000, 1'b1, 5'd2, 16'hA001, 8'd0};
    // fairness: A=2, B=3; ptr -> 0
    tbl[2]  = '{1'b1, 4'b1111, a_dist, d_dist, 4'b1100, 1'b1, 5'd3, 16'hA002, 1'b1, 5'd4, 16'hA003, 8'd0};
    // collision: 0,1 at addr 5, 2 at addr 9 -> A=0, B=2, 1 skipped; ptr -> 3
    tbl[3]  = '{1'b1, 4'b0111, {5'd4, 5'd9, 5'd5, 5'd5}, d_dist, 4'b0101, 1'b1, 5'd5, 16'hA000, 1'b1, 5'd9, 16'hA002, 8'd1};
    // deferred req 1 granted on A next cycle; ptr -> 2
    tbl[4]  = '{1'b1, 4'b0010, {5'd4, 5'd9, 5'd5, 5'd5}, d_dist, 4'b0010, 1'b1, 5'd5, 16'hA001, 1'b0, 5'd0, 16'h0, 8'd1};
    // idle: no grants, ptr stays 2
    tbl[5]  = '{1'b1, 4'b0000, a_dist, d_dist, 4'b0000, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 8'd1};
    // single request on req 2, addr 7, data 0x1234; ptr -> 3
    tbl[6]  = '{1'b1, 4'b0100, {5'd4, 5'd7, 5'd2, 5'd1}, {16'hA003, 16'h1234, 16'hA001, 16'hA000},
                4'b0100, 1'b1, 5'd7, 16'h1234, 1'b0, 5'd0, 16'h0, 8'd1};
    // wrap: ptr 3, reqs 3 and 0 -> A=3, B=0; ptr -> 1
    tbl[7]  = '{1'b1, 4'b1001, {5'd9, 5'd7, 5'd2, 5'd1}, {16'h3333, 16'h1234, 16'hA001, 16'hA000},
                4'b1001, 1'b1, 5'd9, 16'h3333, 1'b1, 5'd1, 16'hA000, 8'd1};
    // ptr 1, all valid: A=1, B=2; ptr -> 3
    tbl[8]  = '{1'b1, 4'b1111, a_dist, d_dist, 4'b0110, 1'b1, 5'd2, 16'hA001, 1'b1, 5'd3, 16'hA002, 8'd1};
    // ptr 3, all valid: A=3, B=0; ptr -> 1
    tbl[9]  = '{1'b1, 4'b1111, a_dist, d_dist, 4'b1001, 1'b1, 5'd4, 16'hA003, 1'b1, 5'd1, 16'hA000, 8'd1};
    // all share addr 8: A=1 only, B idle, conflict; ptr -> 2
    tbl[10] = '{1'b1, 4'b1111, {5'd8, 5'd8, 5'd8, 5'd8}, d_dist, 4'b0010, 1'b1, 5'd8, 16'hA001, 1'b0, 5'd0, 16'h0, 8'd2};

    for (int k = 0; k < 11; k++) begin
      apply(tbl[k], k);
    end

    // Mid-operation reset: grants suppressed, state cleared, ptr back to 0.
    @(negedge clk);
    rst_n = 1'b0;
    valid = 4'b1111;
    addr  = a_dist;
    data  = d_dist;
    #1;
    check("rst ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    check("rst wbA", 32'(wbA), 32'h0);
    check("rst wbB", 32'(wbB), 32'h0);
    check("rst addrA", 32'(wbAddrA), 32'h0);
    check("rst valB", 32'(wbValB), 32'h0);
    check("rst cnt", 32'(cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst ready", 32'(ready), 32'h3);
    @(posedge clk);
    #1;
    check("post-rst addrA", 32'(wbAddrA), 32'd1);
    check("post-rst addrB", 32'(wbAddrB), 32'd2);

    // Saturation: two requesters at the same address collide every cycle.
    @(negedge clk);
    valid = 4'b0011;
    addr  = {5'd4, 5'd3, 5'd5, 5'd5};
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 1 || c == 254 || c == 255 || c == 256 || c == 300) begin
        check($sformatf("sat cnt@%0d", c), 32'(cnt), (c < 255) ? 32'(c) : 32'd255);
      end
    end
    check("sat wbA", 32'(wbA), 32'h1);
    check("sat wbB", 32'(wbB), 32'h0);

    @(negedge clk);
    valid = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
